fft_twiddle_ctrl: RTL and testbench

Sequencer for the in-place radix-2 DIT FFT datapath. On a start pulse it walks every stage and every butterfly and issues one butterfly per cycle: operand read addresses for the data memory and the twiddle ROM address that feeds the twiddle multiplier. It delays each operand address pair through a pipeline matched to memory-read, twiddle-multiply and butterfly latency, so write-back addresses arrive aligned with results. It drains the pipeline between stages so in-place reads never overtake pending writes.

---
 rtl/fft_twiddle_ctrl_pkg.sv | 32 +++
 rtl/fft_addr_pipe.sv | 45 ++++
 rtl/fft_twiddle_ctrl.sv | 161 ++++++++++++++++
 tb/tb_fft_twiddle_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fft_twiddle_ctrl_pkg.sv
// fft_twiddle_ctrl_pkg: build switches and butterfly address helpers
// shared by the FFT sequencer and its write-back delay line.
`ifndef ON
`define ON 1
`endif
`ifndef OFF
`define OFF 0
`endif
`ifndef CLOCK_UP
`define CLOCK_UP `ON
`endif

package fft_twiddle_ctrl_pkg;

   // Lower operand index of butterfly k in stage s (in-place DIT).
   function automatic int unsigned bf_lo(int unsigned s,
                                         int unsigned k);
      int unsigned msk;
      msk = (32'd1 << s) - 32'd1;
      return ((k >> s) << (s + 32'd1)) | (k & msk);
   endfunction

   // Twiddle ROM index: position within the group, scaled to N/2.
   function automatic int unsigned bf_tw(int unsigned lg,
                                         int unsigned s,
                                         int unsigned k);
      int unsigned msk;
      msk = (32'd1 << s) - 32'd1;
      return (k & msk) << (lg - 32'd1 - s);
   endfunction

endpackage

// File: rtl/fft_addr_pipe.sv
// fft_addr_pipe: fixed-depth delay line carrying issue strobe and
// operand addresses so they line up with butterfly results.
module fft_addr_pipe
   import fft_twiddle_ctrl_pkg::*;
#(
   parameter int DEPTH = 3,
   parameter int AW    = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [AW-1:0] in_a,
   input  logic [AW-1:0] in_b,
   output logic          out_valid,
   output logic [AW-1:0] out_a,
   output logic [AW-1:0] out_b
);

   logic [DEPTH-1:0]         v_q;
   logic [DEPTH-1:0][AW-1:0] a_q;
   logic [DEPTH-1:0][AW-1:0] b_q;

   // Shift every cycle; reset flushes any pending write-back.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_q <= '0;
         a_q <= '0;
         b_q <= '0;
      end else begin
         v_q[0] <= in_valid;
         a_q[0] <= in_a;
         b_q[0] <= in_b;
         for (int i = 1; i < DEPTH; i++) begin
            v_q[i] <= v_q[i-1];
            a_q[i] <= a_q[i-1];
            b_q[i] <= b_q[i-1];
         end
      end
   end

   assign out_valid = v_q[DEPTH-1];
   assign out_a     = a_q[DEPTH-1];
   assign out_b     = b_q[DEPTH-1];

endmodule

// File: rtl/fft_twiddle_ctrl.sv
// fft_twiddle_ctrl: stage/butterfly sequencer for an in-place radix-2
// DIT FFT; issues one butterfly per cycle and drains between stages.
module fft_twiddle_ctrl
   import fft_twiddle_ctrl_pkg::*;
#(
   parameter  int LOG2N   = 3,
   parameter  int RD_LAT  = 1,
   parameter  int MUL_LAT = (`CLOCK_UP == `ON) ? 1 : 0,
   parameter  int BF_LAT  = 1,
   localparam int PIPE    = RD_LAT + MUL_LAT + BF_LAT,
   localparam int SW      = (LOG2N > 1) ? $clog2(LOG2N) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             hold,
   output logic             busy,
   output logic             done,
   output logic [SW-1:0]    stage,
   output logic             rd_en,
   output logic [LOG2N-1:0] rd_addr_a,
   output logic [LOG2N-1:0] rd_addr_b,
   output logic [LOG2N-2:0] tw_addr,
   output logic             wr_en,
   output logic [LOG2N-1:0] wr_addr_a,
   output logic [LOG2N-1:0] wr_addr_b
);

   localparam int KW = LOG2N - 1;
   localparam int TW = LOG2N - 1;
   localparam int DW = $clog2(PIPE + 1);

   localparam logic [KW-1:0] KLAST = '1;
   localparam logic [DW-1:0] DLAST = DW'(PIPE - 1);
   localparam logic [SW-1:0] SLAST = SW'(LOG2N - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t        state, state_n;
   logic [SW-1:0] s, s_n;
   logic [KW-1:0] k, k_n;
   logic [DW-1:0] d, d_n;
   logic          issue;

   logic [LOG2N-1:0] a_n;
   logic [LOG2N-1:0] b_n;
   logic [TW-1:0]    tw_n;

   // State and loop counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         s     <= '0;
         k     <= '0;
         d     <= '0;
      end else begin
         state <= state_n;
         s     <= s_n;
         k     <= k_n;
         d     <= d_n;
      end
   end

   // Next state: issue unless held, then drain PIPE cycles per stage.
   always_comb begin
      state_n = state;
      s_n     = s;
      k_n     = k;
      d_n     = d;
      issue   = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (start) begin
               state_n = S_RUN;
               s_n     = '0;
               k_n     = '0;
            end
         end
         S_RUN: begin
            if (!hold) begin
               issue = 1'b1;
               k_n   = k + KW'(1);
               if (k == KLAST) begin
                  state_n = S_DRAIN;
                  k_n     = '0;
                  d_n     = '0;
               end
            end
         end
         S_DRAIN: begin
            d_n = d + DW'(1);
            if (d == DLAST) begin
               d_n = '0;
               if (s == SLAST) begin
                  state_n = S_DONE;
               end else begin
                  state_n = S_RUN;
                  s_n     = s + SW'(1);
                  k_n     = '0;
               end
            end
         end
         S_DONE: begin
            state_n = S_IDLE;
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   // Operand and twiddle addresses for butterfly k of stage s.
   always_comb begin
      a_n  = LOG2N'(bf_lo(32'(s), 32'(k)));
      b_n  = a_n | (LOG2N'(1) << s);
      tw_n = TW'(bf_tw(LOG2N, 32'(s), 32'(k)));
   end

   // Registered outputs; addresses hold between issues.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy      <= 1'b0;
         done      <= 1'b0;
         stage     <= '0;
         rd_en     <= 1'b0;
         rd_addr_a <= '0;
         rd_addr_b <= '0;
         tw_addr   <= '0;
      end else begin
         busy  <= (state == S_RUN) || (state == S_DRAIN);
         done  <= (state == S_DONE);
         stage <= s;
         rd_en <= issue;
         if (issue) begin
            rd_addr_a <= a_n;
            rd_addr_b <= b_n;
            tw_addr   <= tw_n;
         end
      end
   end

   fft_addr_pipe #(
      .DEPTH (PIPE),
      .AW    (LOG2N)
   ) u_pipe (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (rd_en),
      .in_a      (rd_addr_a),
      .in_b      (rd_addr_b),
      .out_valid (wr_en),
      .out_a     (wr_addr_a),
      .out_b     (wr_addr_b)
   );

endmodule

// File: tb/tb_fft_twiddle_ctrl.sv
// tb_fft_twiddle_ctrl: random hold/start stimulus against a schedule
// model built from the FFT stage/group/pair loop nest.
module tb_fft_twiddle_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst0, start0, hold0;
   logic       busy0, done0, rd0, wr0;
   logic [1:0] stage0;
   logic [2:0] ra0, rb0, wa0, wb0;
   logic [1:0] tw0;

   logic       rst1, start1, hold1;
   logic       busy1, done1, rd1, wr1;
   logic [1:0] stage1;
   logic [3:0] ra1, rb1, wa1, wb1;
   logic [2:0] tw1;

   fft_twiddle_ctrl u0 (
      .clk(clk), .rst(rst0), .start(start0), .hold(hold0),
      .busy(busy0), .done(done0), .stage(stage0),
      .rd_en(rd0), .rd_addr_a(ra0), .rd_addr_b(rb0),
      .tw_addr(tw0), .wr_en(wr0),
      .wr_addr_a(wa0), .wr_addr_b(wb0)
   );

   fft_twiddle_ctrl #(.LOG2N(4), .MUL_LAT(0)) u1 (
      .clk(clk), .rst(rst1), .start(start1), .hold(hold1),
      .busy(busy1), .done(done1), .stage(stage1),
      .rd_en(rd1), .rd_addr_a(ra1), .rd_addr_b(rb1),
      .tw_addr(tw1), .wr_en(wr1),
      .wr_addr_a(wa1), .wr_addr_b(wb1)
   );

   int total, bad;
   int o_busy, o_done, o_stage, o_rd, o_a, o_b, o_tw;
   int o_wr, o_wa, o_wb;

   int e_busy[1024], e_done[1024], e_stage[1024];
   int e_rd[1024], e_a[1024], e_b[1024], e_tw[1024];
   bit hold_arr[1024];
   int last_a[2], last_b[2], last_tw[2];

   task automatic check(input string tag, input int got,
                        input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s @%0t got=%0d exp=%0d",
                  tag, $time, got, exp);
      end
   endtask

   task automatic drive(input int w, input logic st,
                        input logic hd, input logic rs);
      if (w == 0) begin
         start0 = st; hold0 = hd; rst0 = rs;
      end else begin
         start1 = st; hold1 = hd; rst1 = rs;
      end
   endtask

   task automatic grab(input int w);
      if (w == 0) begin
         o_busy = int'(busy0); o_done = int'(done0);
         o_stage = int'(stage0); o_rd = int'(rd0);
         o_a = int'(ra0); o_b = int'(rb0); o_tw = int'(tw0);
         o_wr = int'(wr0); o_wa = int'(wa0); o_wb = int'(wb0);
      end else begin
         o_busy = int'(busy1); o_done = int'(done1);
         o_stage = int'(stage1); o_rd = int'(rd1);
         o_a = int'(ra1); o_b = int'(rb1); o_tw = int'(tw1);
         o_wr = int'(wr1); o_wa = int'(wa1); o_wb = int'(wb1);
      end
   endtask

   task automatic check_zero(input int w, input string where);
      grab(w);
      check({where, ".busy"}, o_busy, 0);
      check({where, ".done"}, o_done, 0);
      check({where, ".stage"}, o_stage, 0);
      check({where, ".rd_en"}, o_rd, 0);
      check({where, ".rd_a"}, o_a, 0);
      check({where, ".rd_b"}, o_b, 0);
      check({where, ".tw"}, o_tw, 0);
      check({where, ".wr_en"}, o_wr, 0);
      check({where, ".wr_a"}, o_wa, 0);
      check({where, ".wr_b"}, o_wb, 0);
   endtask

   // hold_pct < 0 selects hold in cycles 2 and 3 only.
   task automatic run(input int w, input int hold_pct,
                      input int start_pct, input bit extra,
                      input int rst_at, input bit chain);
      int lg, pipe, nb, t, idx, tdone, nis, pc;
      int qa[$], qb[$], qt[$];
      int ca, cb, ct;
      bit st;
      lg   = (w == 0) ? 3 : 4;
      pipe = (w == 0) ? 3 : 2;
      nb   = 1 << (lg - 1);
      for (int s = 0; s < lg; s++) begin
         int span;
         span = 1 << s;
         for (int g = 0; g < nb / span; g++)
            for (int j = 0; j < span; j++) begin
               qa.push_back(g * 2 * span + j);
               qb.push_back(g * 2 * span + j + span);
               qt.push_back(j * (nb / span));
            end
      end
      for (int c = 0; c < 1024; c++) begin
         if (hold_pct < 0)
            hold_arr[c] = (c == 2 || c == 3);
         else
            hold_arr[c] = (c < 700) &&
               (int'($urandom_range(99)) < hold_pct);
      end
      ca = last_a[w]; cb = last_b[w]; ct = last_tw[w];
      e_busy[0] = 0; e_done[0] = 0; e_rd[0] = 0;
      e_stage[0] = 0;
      e_a[0] = ca; e_b[0] = cb; e_tw[0] = ct;
      t = 1;
      idx = 0;
      for (int s = 0; s < lg; s++) begin
         nis = 0;
         while (nis < nb) begin
            e_busy[t] = 1; e_done[t] = 0; e_stage[t] = s;
            e_rd[t] = 0;
            if (!hold_arr[t]) begin
               e_rd[t] = 1;
               ca = qa[idx]; cb = qb[idx]; ct = qt[idx];
               idx++;
               nis++;
            end
            e_a[t] = ca; e_b[t] = cb; e_tw[t] = ct;
            t++;
         end
         for (int p = 0; p < pipe; p++) begin
            e_busy[t] = 1; e_done[t] = 0; e_stage[t] = s;
            e_rd[t] = 0;
            e_a[t] = ca; e_b[t] = cb; e_tw[t] = ct;
            t++;
         end
      end
      tdone = t;
      e_busy[t] = 0; e_done[t] = 1; e_stage[t] = lg - 1;
      e_rd[t] = 0;
      e_a[t] = ca; e_b[t] = cb; e_tw[t] = ct;

      @(negedge clk);
      drive(w, 1'b1, hold_arr[0], 1'b0);
      @(posedge clk);
      for (int c = 1; c <= tdone; c++) begin
         @(negedge clk);
         st = (extra && (c == 5 || c == tdone)) ||
              (start_pct > 0 &&
               int'($urandom_range(99)) < start_pct);
         drive(w, st, hold_arr[c], 1'b0);
         @(posedge clk);
         #1;
         if (c == rst_at) begin
            drive(w, 1'b0, 1'b0, 1'b1);
            #1;
            check_zero(w, "rst_mid");
            for (int i = 0; i < 2 * pipe + 2; i++) begin
               @(negedge clk);
               drive(w, 1'b0, 1'b0, 1'b0);
               @(posedge clk);
               #1;
               grab(w);
               check("post_rst.rd_en", o_rd, 0);
               check("post_rst.wr_en", o_wr, 0);
               check("post_rst.busy", o_busy, 0);
               check("post_rst.done", o_done, 0);
            end
            last_a[w] = 0; last_b[w] = 0; last_tw[w] = 0;
            return;
         end
         grab(w);
         pc = (c > pipe) ? c - pipe : 0;
         check("busy", o_busy, e_busy[c]);
         check("done", o_done, e_done[c]);
         check("rd_en", o_rd, e_rd[c]);
         if (e_busy[c] != 0)
            check("stage", o_stage, e_stage[c]);
         check("rd_a", o_a, e_a[c]);
         check("rd_b", o_b, e_b[c]);
         check("tw", o_tw, e_tw[c]);
         check("wr_en", o_wr, e_rd[pc]);
         check("wr_a", o_wa, e_a[pc]);
         check("wr_b", o_wb, e_b[pc]);
      end
      last_a[w] = ca; last_b[w] = cb; last_tw[w] = ct;
      if (!chain) begin
         @(negedge clk);
         drive(w, 1'b0, 1'b0, 1'b0);
         @(posedge clk);
         #1;
         grab(w);
         check("idle.busy", o_busy, 0);
         check("idle.done", o_done, 0);
         check("idle.wr_en", o_wr, 0);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      last_a = '{0, 0}; last_b = '{0, 0}; last_tw = '{0, 0};
      drive(0, 1'b1, 1'b0, 1'b1);
      drive(1, 1'b1, 1'b0, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      check_zero(0, "reset0");
      check_zero(1, "reset1");
      @(negedge clk);
      drive(0, 1'b0, 1'b0, 1'b0);
      drive(1, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      run(0, 0, 0, 1'b1, -1, 1'b1);
      run(0, -1, 0, 1'b0, -1, 1'b0);
      repeat (3) run(0, 30, 20, 1'b0, -1, 1'b0);
      run(0, 0, 0, 1'b0, 9, 1'b0);
      run(0, 0, 0, 1'b0, -1, 1'b0);
      run(0, 20, 10, 1'b0, -1, 1'b1);
      run(0, 0, 0, 1'b0, -1, 1'b0);
      run(1, 0, 0, 1'b0, -1, 1'b0);
      repeat (2) run(1, 25, 20, 1'b0, -1, 1'b0);
      run(1, 10, 0, 1'b0, 20, 1'b0);
      run(1, 0, 0, 1'b0, -1, 1'b0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
